ccd_frame_reader: RTL and testbench
===================================

# ccd_frame_reader

Drains one CCD line (1024 pixel bytes) from the pixel FIFO that the CCD/ADC acquisition block fills. Wraps the line in the serial frame protocol: header, length, pixels and an optional checksum. Presents the bytes one at a time to the UART transmitter over a valid/ready handshake. It is the read side of the FIFO that the acquisition block writes, and it is started by that block's `serialsend_flag`.

## Interface
- `PIXELS`, 1024: pixel bytes per frame; also the value sent in the length field.
- `HDR0`, 8'hAA: first header byte.
- `HDR1`, 8'h55: second header byte.
- `USEDW_W`, 11: width of the FIFO read-side used-words count.
- Reset is asynchronous, active-high.

Ports:
- `clk`  in  1  single system clock; also the FIFO read clock.
- `rst`  in  1  asynchronous active-high reset.
- `send_flag`  in  1  `serialsend_flag` from the acquisition block; high while a line is being written.
- `rd_data`  in  8  FIFO `q`, normal (non-show-ahead) mode, valid the cycle after `rdreq`.
- `rdempty`  in  1  FIFO read-side empty.
- `rdusedw`  in  `USEDW_W`  FIFO read-side fill level; status only, not used for flow control.
- `rdreq`  out  1  FIFO read request; single-cycle pulse per byte.
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  UART accepts the byte.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse after the last byte is accepted.
- `err_underrun`  out  1  sticky; the frame was padded.

## Operation
**States:** IDLE, HDR0, HDR1, LEN_H, LEN_L, RD_REQ, RD_CAP, PIX, SUM, DONE.

**IDLE:**
- Registered `send_flag` 0→1 edge → HDR0; clears `err_underrun`, pixel counter and checksum.
- Edges while not in IDLE are ignored.

**Header and length:**
- HDR0, HDR1, LEN_H, LEN_L each drive `tx_valid`=1 with `HDR0`, `HDR1`, `PIXELS[15:8]`, `PIXELS[7:0]`.
- Advance only when `tx_valid && tx_ready`.

**Pixel read (RD_REQ):**
- If `!rdempty`: pulse `rdreq` → RD_CAP.
- If `rdempty && send_flag`: wait.
- If `rdempty && !send_flag`, pixels remaining: the writer has finished and data is short. Set `err_underrun`, load 0x00 and go to PIX without `rdreq`.
- Once `err_underrun` is set, all remaining pixels are padded with 0x00 without reading the FIFO.

**RD_CAP:** capture `rd_data` into `tx_data` → PIX.

**PIX:**
- Hold `tx_valid`=1 until accepted.
- On accept: checksum += byte (mod 256), counter += 1.
- Counter == `PIXELS` → SUM (or DONE when the checksum is compiled out); else → RD_REQ.

**SUM:** send the checksum byte → DONE.

**DONE:** pulse `frame_done`, drop `busy` → IDLE.

**Handshake rules:**
- `tx_data` is stable while `tx_valid`=1 and not yet accepted.
- `tx_valid` never drops without acceptance.
- `busy` is 1 from HDR0 through DONE.

**Arithmetic:**
- Pixel counter is 16 bit.
- Checksum is an 8-bit wrapping sum of the transmitted pixel bytes, including padding; the header and length bytes are not summed.

## Timing
- Reset values: `rdreq`=0, `tx_data`=0x00, `tx_valid`=0, `busy`=0, `frame_done`=0, `err_underrun`=0, state IDLE.
- Reset mid-frame aborts the frame immediately. The FIFO is not flushed; the FIFO owner handles its `aclr`.
- `send_flag` rises at edge N → edge detected at N+1 → `tx_valid` high with `HDR0` from N+2.
- Per pixel with `tx_ready` tied high and the FIFO non-empty: `rdreq` (1 cycle), capture (1), transfer (1). That is 3 cycles per byte.
- A frame then takes 4 + 3·`PIXELS` + 1 (+1 checksum) cycles.
- `frame_done` asserts the cycle after the final accept.

## Configuration
- `CCD_FRAME_CHECKSUM_EN` defined: the SUM state exists and the frame is `PIXELS`+5 bytes.
- Undefined: SUM and the accumulator are removed, PIX goes straight to DONE, and the frame is `PIXELS`+4 bytes.

## Structure
- Package `ccd_frame_pkg` holds the state enum, the default `HDR0`/`HDR1`, and the default `PIXELS`.
- No sub-module; the edge detector, counter and checksum accumulator are inline.

## Test plan
- **Normal frame:** FIFO preloaded with 0x00..0xFF ×4, `send_flag` pulse, `tx_ready`=1.
  - Output: AA 55 04 00, 1024 bytes in order, checksum 0x00; `frame_done` once; `err_underrun`=0.
- **Backpressure:** `tx_ready` toggles 1-in-3 cycles.
  - Identical byte stream; `tx_data` never changes while `tx_valid`=1 and not yet accepted.
- **Underrun:** 1000 bytes in the FIFO, then `send_flag` falls.
  - Last 24 pixels are 0x00; `err_underrun`=1; no `rdreq` with `rdempty`=1.
- **Slow writer:** FIFO fed 1 byte / 100 cycles while `send_flag`=1.
  - The block stalls in RD_REQ, with no padding and no error.
- **Reset mid-frame:** assert `rst` after 10 pixels.
  - All outputs return to reset values the same cycle; a new `send_flag` edge restarts from AA.
- **Second edge while busy:** ignored; exactly one `frame_done`.

Source files
------------

// File: rtl/ccd_frame_pkg.sv
// Shared types and defaults for the CCD line-to-serial frame reader.
// The optional checksum state is enabled by CCD_FRAME_CHECKSUM_EN.
package ccd_frame_pkg;

    localparam int         PIXELS_DEF  = 1024;
    localparam logic [7:0] HDR0_DEF    = 8'hAA;
    localparam logic [7:0] HDR1_DEF    = 8'h55;
    localparam int         USEDW_W_DEF = 11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_LEN_H,
        S_LEN_L,
        S_RD_REQ,
        S_RD_CAP,
        S_PIX,
        S_SUM,
        S_DONE
    } state_e;

endpackage

// File: rtl/ccd_frame_reader.sv
// Drains one CCD line from the pixel FIFO and frames it for the UART.
// Define CCD_FRAME_CHECKSUM_EN to append the 8-bit pixel checksum byte.
module ccd_frame_reader
    import ccd_frame_pkg::*;
#(
    parameter int         PIXELS  = PIXELS_DEF,
    parameter logic [7:0] HDR0    = HDR0_DEF,
    parameter logic [7:0] HDR1    = HDR1_DEF,
    parameter int         USEDW_W = USEDW_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               send_flag,
    input  logic [7:0]         rd_data,
    input  logic               rdempty,
    input  logic [USEDW_W-1:0] rdusedw,
    output logic               rdreq,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               err_underrun
);

    localparam logic [15:0] LEN = 16'(PIXELS);

    state_e      state_q, state_d;
    logic        sf_q, sf_d1_q;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  pix_q, pix_d;
    logic        err_q, err_d;
    logic        rise;
    logic        unused_usedw;
`ifdef CCD_FRAME_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    // Fill level is informational only; flow control uses rdempty.
    assign unused_usedw = ^rdusedw;
    assign rise         = sf_q & ~sf_d1_q;
    assign busy         = (state_q != S_IDLE);
    assign err_underrun = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sf_q    <= 1'b0;
            sf_d1_q <= 1'b0;
            cnt_q   <= 16'd0;
            pix_q   <= 8'h00;
            err_q   <= 1'b0;
`ifdef CCD_FRAME_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            sf_q    <= send_flag;
            sf_d1_q <= sf_q;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            err_q   <= err_d;
`ifdef CCD_FRAME_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pix_d      = pix_q;
        err_d      = err_q;
`ifdef CCD_FRAME_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        rdreq      = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        frame_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_HDR0;
                    cnt_d   = 16'd0;
                    err_d   = 1'b0;
`ifdef CCD_FRAME_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            S_HDR0: begin
                tx_valid = 1'b1;
                tx_data  = HDR0;
                if (tx_ready) state_d = S_HDR1;
            end
            S_HDR1: begin
                tx_valid = 1'b1;
                tx_data  = HDR1;
                if (tx_ready) state_d = S_LEN_H;
            end
            S_LEN_H: begin
                tx_valid = 1'b1;
                tx_data  = LEN[15:8];
                if (tx_ready) state_d = S_LEN_L;
            end
            S_LEN_L: begin
                tx_valid = 1'b1;
                tx_data  = LEN[7:0];
                if (tx_ready) state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                // After a short line every remaining pixel is zero padding.
                if (err_q) begin
                    pix_d   = 8'h00;
                    state_d = S_PIX;
                end else if (!rdempty) begin
                    rdreq   = 1'b1;
                    state_d = S_RD_CAP;
                end else if (!send_flag) begin
                    err_d   = 1'b1;
                    pix_d   = 8'h00;
                    state_d = S_PIX;
                end
            end
            S_RD_CAP: begin
                pix_d   = rd_data;
                state_d = S_PIX;
            end
            S_PIX: begin
                tx_valid = 1'b1;
                tx_data  = pix_q;
                if (tx_ready) begin
                    cnt_d = cnt_q + 16'd1;
`ifdef CCD_FRAME_CHECKSUM_EN
                    sum_d = sum_q + pix_q;
                    if (cnt_d == LEN) state_d = S_SUM;
                    else              state_d = S_RD_REQ;
`else
                    if (cnt_d == LEN) state_d = S_DONE;
                    else              state_d = S_RD_REQ;
`endif
                end
            end
`ifdef CCD_FRAME_CHECKSUM_EN
            S_SUM: begin
                tx_valid = 1'b1;
                tx_data  = sum_q;
                if (tx_ready) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ccd_frame_reader.sv
// Self-checking bench for ccd_frame_reader: FIFO model, UART sink, frame model.
// Honours CCD_FRAME_CHECKSUM_EN the same way as the design.
module tb_ccd_frame_reader;
    import ccd_frame_pkg::*;

    localparam int NPIX = PIXELS_DEF;
`ifdef CCD_FRAME_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        send_flag = 1'b0;
    logic [7:0]  rd_data;
    logic        rdempty;
    logic [10:0] rdusedw;
    logic        rdreq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        frame_done;
    logic        err_underrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ccd_frame_reader dut (
        .clk          (clk),
        .rst          (rst),
        .send_flag    (send_flag),
        .rd_data      (rd_data),
        .rdempty      (rdempty),
        .rdusedw      (rdusedw),
        .rdreq        (rdreq),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_underrun (err_underrun)
    );

    // Normal-mode FIFO: q valid the cycle after rdreq; cleared by rst.
    logic [7:0] fq[$];
    logic       push_en = 1'b0;
    logic [7:0] push_byte = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            rd_data <= 8'h00;
            rdempty <= 1'b1;
            rdusedw <= 11'd0;
        end else begin
            if (rdreq && fq.size() > 0) rd_data <= fq.pop_front();
            if (push_en) fq.push_back(push_byte);
            rdempty <= (fq.size() == 0);
            rdusedw <= 11'(fq.size());
        end
    end

    // UART sink: drives tx_ready, records accepted bytes, checks holds.
    logic [7:0] cap[$];
    int         done_cnt = 0;
    int         busy_cyc = 0;
    int         cyc = 0;
    int         ready_mode = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_data = 8'h00;

    always @(negedge clk) begin
        cyc++;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                total++;
                if (!tx_valid || tx_data !== pend_data) begin
                    bad++;
                    $display("FAIL hold: valid=%b data=%02h want valid=1 data=%02h",
                             tx_valid, tx_data, pend_data);
                end
            end
            if (rdreq) begin
                total++;
                if (rdempty) begin
                    bad++;
                    $display("FAIL rdreq_on_empty: rdempty=%b want 0", rdempty);
                end
            end
            if (tx_valid && tx_ready) cap.push_back(tx_data);
            pend      = tx_valid && !tx_ready;
            pend_data = tx_data;
            if (frame_done) done_cnt++;
            if (busy) busy_cyc++;
        end
    end

    // Reference frame: header, length, line padded with zeros, checksum.
    logic [7:0] exp_q[$];

    function automatic void make_frame(input logic [7:0] px[$]);
        int         n = NPIX;
        logic [7:0] b;
        logic [7:0] s = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'((n >> 8) & 255));
        exp_q.push_back(8'(n & 255));
        for (int i = 0; i < n; i++) begin
            b = (i < px.size()) ? px[i] : 8'h00;
            s = s + b;
            exp_q.push_back(b);
        end
        if (CS != 0) exp_q.push_back(s);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_stream(input string nm, input int base);
        int nb = 0;
        int first = -1;
        int n = cap.size() - base;
        chk({nm, "_len"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            if (cap[base + i] !== exp_q[i]) begin
                nb++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (nb != 0) begin
            bad++;
            $display("FAIL %s_bytes: %0d wrong, first at %0d got %02h want %02h",
                     nm, nb, first, cap[base + first], exp_q[first]);
        end
    endtask

    task automatic do_reset();
        send_flag = 1'b0;
        push_en   = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_one(input logic [7:0] b);
        @(negedge clk);
        push_en   = 1'b1;
        push_byte = b;
        @(negedge clk);
        push_en   = 1'b0;
    endtask

    task automatic pulse_flag();
        @(negedge clk);
        send_flag = 1'b1;
        repeat (3) @(negedge clk);
        send_flag = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL %s_timeout: frame_done count %0d want %0d", nm, done_cnt, d0 + 1);
        end
    endtask

    task automatic wait_cap(input int target);
        int n = 0;
        while (cap.size() < target && n < 10000) begin
            @(posedge clk);
            n++;
        end
        chk("cap_progress", int'(cap.size() >= target), 1);
    endtask

    typedef struct {
        string name;
        int    n_pre;
        int    pat;
        int    rmode;
        int    slow;
        int    exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] px[$];
        int         base;
        int         d0;
        int         b0;

        vecs[0] = '{"normal",     1024, 0, 0, 0,  0};
        vecs[1] = '{"backpres",   1024, 0, 1, 0,  0};
        vecs[2] = '{"underrun",   1000, 1, 0, 0,  1};
        vecs[3] = '{"slow",       1024, 1, 2, 20, 0};
        vecs[4] = '{"rand",       1024, 1, 2, 0,  0};
        vecs[5] = '{"rand_under", 600,  1, 2, 0,  1};

        #1;
        rst = 1'b1;
        #2;
        chk("rst_rdreq",      rdreq,        0);
        chk("rst_tx_data",    tx_data,      0);
        chk("rst_tx_valid",   tx_valid,     0);
        chk("rst_busy",       busy,         0);
        chk("rst_frame_done", frame_done,   0);
        chk("rst_err",        err_underrun, 0);

        foreach (vecs[k]) begin
            do_reset();
            ready_mode = vecs[k].rmode;
            px.delete();
            for (int i = 0; i < vecs[k].n_pre; i++)
                px.push_back((vecs[k].pat == 0) ? 8'(i & 255) : 8'($urandom_range(0, 255)));
            make_frame(px);
            base = cap.size();
            d0   = done_cnt;
            b0   = busy_cyc;
            if (vecs[k].slow == 0) begin
                foreach (px[i]) push_one(px[i]);
                pulse_flag();
            end else begin
                @(negedge clk);
                send_flag = 1'b1;
                foreach (px[i]) begin
                    if (i < vecs[k].slow) repeat (98) @(negedge clk);
                    push_one(px[i]);
                end
                send_flag = 1'b0;
            end
            wait_done(vecs[k].name, d0);
            repeat (5) @(negedge clk);
            #2;
            cmp_stream(vecs[k].name, base);
            chk({vecs[k].name, "_err"}, err_underrun, vecs[k].exp_err);
            chk({vecs[k].name, "_done_once"}, done_cnt - d0, 1);
            chk({vecs[k].name, "_fifo_left"}, fq.size(), 0);
            if (vecs[k].rmode == 0 && vecs[k].exp_err == 0)
                chk({vecs[k].name, "_cycles"}, busy_cyc - b0, 4 + 3 * NPIX + 1 + CS);
        end

        // Start latency, then reset mid-frame and restart from the header.
        do_reset();
        ready_mode = 0;
        px.delete();
        for (int i = 0; i < NPIX; i++) px.push_back(8'($urandom_range(0, 255)));
        foreach (px[i]) push_one(px[i]);
        base = cap.size();
        @(posedge clk);
        #1 send_flag = 1'b1;
        @(posedge clk);
        #1 chk("lat_valid_n1", tx_valid, 0);
        @(posedge clk);
        #1 chk("lat_valid_n2", tx_valid, 1);
        chk("lat_data_n2", tx_data, 8'hAA);
        send_flag = 1'b0;
        wait_cap(base + 14);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rdreq",      rdreq,        0);
        chk("mid_tx_data",    tx_data,      0);
        chk("mid_tx_valid",   tx_valid,     0);
        chk("mid_busy",       busy,         0);
        chk("mid_frame_done", frame_done,   0);
        chk("mid_err",        err_underrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        make_frame(px);
        foreach (px[i]) push_one(px[i]);
        #2;
        base = cap.size();
        d0   = done_cnt;
        pulse_flag();
        wait_done("restart", d0);
        repeat (5) @(negedge clk);
        #2;
        cmp_stream("restart", base);

        // A second send_flag edge during a frame must not start another.
        do_reset();
        ready_mode = 2;
        px.delete();
        for (int i = 0; i < NPIX; i++) px.push_back(8'($urandom_range(0, 255)));
        make_frame(px);
        foreach (px[i]) push_one(px[i]);
        #2;
        base = cap.size();
        d0   = done_cnt;
        pulse_flag();
        wait_cap(base + 50);
        pulse_flag();
        wait_done("edge2", d0);
        repeat (50) @(negedge clk);
        #2;
        chk("edge2_done_once", done_cnt - d0, 1);
        chk("edge2_idle", busy, 0);
        cmp_stream("edge2", base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
